// File: rtl/uart_tmct_ctrl_if.sv
// rtl/uart_tmct_ctrl_if.sv - openMSP430 peripheral-bus bundle for the uart_tmct_ctrl register front-end
interface uart_tmct_ctrl_if;
  logic        per_en;
  logic [1:0]  per_we;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic [15:0] per_dout;

  modport master (output per_en, per_we, per_addr, per_din, input per_dout);
  modport slave  (input per_en, per_we, per_addr, per_din, output per_dout);
endinterface

// File: rtl/uart_tmct_ctrl.sv
// rtl/uart_tmct_ctrl.sv - peripheral registers, TX/RX FIFOs and core handshake FSMs for uart_tmct_top
// Optional registered interrupt output and RXIE/TXIE bits: define UART_TMCT_CTRL_IRQ_EN.
module uart_tmct_ctrl #(
  parameter logic [13:0] BASE_ADDR    = 14'h0040,
  parameter int          TX_DEPTH     = 8,
  parameter int          RX_DEPTH     = 8,
  parameter logic [15:0] DEFAULT_PRER = 16'd5208
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  uart_tmct_ctrl_if.slave        per_bus,
  output logic                   o_txrun,
  output logic [7:0]             o_txdata,
  input  logic                   i_txdone,
  output logic                   o_rxclear,
  input  logic [7:0]             i_rxdata,
  input  logic                   i_rxerr,
  input  logic                   i_rxdone,
  output logic [15:0]            o_prer,
  output logic                   o_irq
);
  localparam int TXW = $clog2(TX_DEPTH);
  localparam int RXW = $clog2(RX_DEPTH);
  localparam logic [TXW:0] TX_FULL_CNT = (TXW+1)'(TX_DEPTH);
  localparam logic [RXW:0] RX_FULL_CNT = (RXW+1)'(RX_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_LAUNCH, TX_WAIT_BUSY, TX_WAIT_DONE} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_ACK, RX_WAIT_LOW} rx_state_e;

  tx_state_e      tx_state_q, tx_state_d;
  rx_state_e      rx_state_q, rx_state_d;
  logic [7:0]     txdata_q, txdata_d;
  logic [15:0]    prer_q, prer_d;
  logic           ovr_q, ovr_d, ferr_q, ferr_d;

  logic [7:0]     tx_mem_q [TX_DEPTH];
  logic [TXW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [TXW:0]   tx_cnt_q, tx_cnt_d;
  logic [8:0]     rx_mem_q [RX_DEPTH];
  logic [RXW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [RXW:0]   rx_cnt_q, rx_cnt_d;

  // Bus decode
  logic rd, wr, hit_ctrl, hit_stat, hit_txd, hit_rxd, hit_prer;
  assign rd       = per_bus.per_en & (per_bus.per_we == 2'b00);
  assign wr       = per_bus.per_en & (per_bus.per_we != 2'b00);
  assign hit_ctrl = (per_bus.per_addr == BASE_ADDR);
  assign hit_stat = (per_bus.per_addr == BASE_ADDR + 14'd1);
  assign hit_txd  = (per_bus.per_addr == BASE_ADDR + 14'd2);
  assign hit_rxd  = (per_bus.per_addr == BASE_ADDR + 14'd3);
  assign hit_prer = (per_bus.per_addr == BASE_ADDR + 14'd4);

  logic ctrl_wr, stat_wr, tx_flush, rx_flush, tx_req;
  assign ctrl_wr  = wr & hit_ctrl & per_bus.per_we[0];
  assign stat_wr  = wr & hit_stat & per_bus.per_we[0];
  assign tx_flush = ctrl_wr & per_bus.per_din[3];
  assign rx_flush = ctrl_wr & per_bus.per_din[2];
  assign tx_req   = wr & hit_txd & per_bus.per_we[0];

  logic tx_empty, tx_full, rx_empty, rx_full, tx_idle_empty;
  assign tx_empty      = (tx_cnt_q == '0);
  assign tx_full       = (tx_cnt_q == TX_FULL_CNT);
  assign rx_empty      = (rx_cnt_q == '0);
  assign rx_full       = (rx_cnt_q == RX_FULL_CNT);
  assign tx_idle_empty = tx_empty & (tx_state_q == TX_IDLE);

  logic tx_pop, tx_push, rx_pop, rx_push, ovr_set, ferr_set;
  assign rx_pop  = rd & hit_rxd & ~rx_empty;
  assign tx_push = tx_req & (~tx_full | tx_pop);

  always_comb begin
    tx_state_d = tx_state_q;
    txdata_d   = txdata_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty && i_txdone) begin
          tx_pop     = 1'b1;
          txdata_d   = tx_mem_q[tx_rptr_q];
          tx_state_d = TX_LAUNCH;
        end
      end
      TX_LAUNCH:    tx_state_d = TX_WAIT_BUSY;
      TX_WAIT_BUSY: if (!i_txdone) tx_state_d = TX_WAIT_DONE;
      TX_WAIT_DONE: if (i_txdone) tx_state_d = TX_IDLE;
      default:      tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_push    = 1'b0;
    ovr_set    = 1'b0;
    ferr_set   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (i_rxdone) begin
          if (!rx_full || rx_pop) rx_push = 1'b1;
          else                    ovr_set = 1'b1;
          ferr_set   = i_rxerr;
          rx_state_d = RX_ACK;
        end
      end
      RX_ACK:      rx_state_d = RX_WAIT_LOW;
      RX_WAIT_LOW: if (!i_rxdone) rx_state_d = RX_IDLE;
      default:     rx_state_d = RX_IDLE;
    endcase
  end

  // Flush wins over any same-cycle push or pop
  always_comb begin
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    if (tx_flush) begin
      tx_wptr_d = '0;
      tx_rptr_d = '0;
      tx_cnt_d  = '0;
    end else begin
      if (tx_push) tx_wptr_d = tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_d = tx_rptr_q + 1'b1;
      if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + 1'b1;
      else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - 1'b1;
    end
  end

  always_comb begin
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    rx_cnt_d  = rx_cnt_q;
    if (rx_flush) begin
      rx_wptr_d = '0;
      rx_rptr_d = '0;
      rx_cnt_d  = '0;
    end else begin
      if (rx_push) rx_wptr_d = rx_wptr_q + 1'b1;
      if (rx_pop)  rx_rptr_d = rx_rptr_q + 1'b1;
      if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + 1'b1;
      else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - 1'b1;
    end
  end

  // A new event in the same cycle as its write-1-to-clear keeps the flag set
  always_comb begin
    ovr_d  = (ovr_q  & ~(stat_wr & per_bus.per_din[3])) | ovr_set;
    ferr_d = (ferr_q & ~(stat_wr & per_bus.per_din[4])) | ferr_set;
    prer_d = prer_q;
    if (wr && hit_prer) begin
      if (per_bus.per_we[0]) prer_d[7:0]  = per_bus.per_din[7:0];
      if (per_bus.per_we[1]) prer_d[15:8] = per_bus.per_din[15:8];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tx_state_q <= TX_IDLE;
      rx_state_q <= RX_IDLE;
      txdata_q   <= '0;
      prer_q     <= DEFAULT_PRER;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_cnt_q   <= '0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_cnt_q   <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      rx_state_q <= rx_state_d;
      txdata_q   <= txdata_d;
      prer_q     <= prer_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_wptr_q  <= rx_wptr_d;
      rx_rptr_q  <= rx_rptr_d;
      rx_cnt_q   <= rx_cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (tx_push) tx_mem_q[tx_wptr_q] <= per_bus.per_din[7:0];
    if (rx_push) rx_mem_q[rx_wptr_q] <= {i_rxerr, i_rxdata};
  end

  logic [1:0] ie_rd;
`ifdef UART_TMCT_CTRL_IRQ_EN
  logic rxie_q, rxie_d, txie_q, txie_d, irq_q, irq_d;
  assign rxie_d = ctrl_wr ? per_bus.per_din[0] : rxie_q;
  assign txie_d = ctrl_wr ? per_bus.per_din[1] : txie_q;
  assign irq_d  = (rxie_q & ~rx_empty) | (txie_q & tx_idle_empty) | ovr_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rxie_q <= 1'b0;
      txie_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      rxie_q <= rxie_d;
      txie_q <= txie_d;
      irq_q  <= irq_d;
    end
  end
  assign ie_rd = {txie_q, rxie_q};
  assign o_irq = irq_q;
`else
  assign ie_rd = 2'b00;
  assign o_irq = 1'b0;
`endif

  logic [7:0]  rx_cnt_ext;
  logic [3:0]  rx_cnt_sat;
  logic [15:0] rd_data;
  assign rx_cnt_ext = 8'(rx_cnt_q);
  assign rx_cnt_sat = (rx_cnt_ext > 8'd15) ? 4'd15 : rx_cnt_ext[3:0];

  always_comb begin
    rd_data = 16'h0000;
    if (rd) begin
      if (hit_ctrl)      rd_data = {14'b0, ie_rd};
      else if (hit_stat) rd_data = {4'b0, rx_cnt_sat, 3'b0, ferr_q, ovr_q,
                                    tx_idle_empty, tx_full, ~rx_empty};
      else if (hit_rxd)  rd_data = rx_empty ? 16'h0000 : {7'b0, rx_mem_q[rx_rptr_q]};
      else if (hit_prer) rd_data = prer_q;
    end
  end

  assign per_bus.per_dout = rd_data;
  assign o_txrun          = (tx_state_q == TX_LAUNCH);
  assign o_txdata         = txdata_q;
  assign o_rxclear        = (rx_state_q == RX_ACK);
  assign o_prer           = prer_q;
endmodule
